// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, baud helper and
// frame-length helper used by the TX/RX paths and their benches.
package uart_pkg;

    // Transmitter bit-phase states; PARITY is only reached when parity is built in
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int unsigned MIN_BIT_CLKS = 4;

    // Clocks per serial bit (integer divide)
    function automatic int unsigned calc_bit_clks(input int unsigned clk_freq,
                                                  input int unsigned baudrate);
        return clk_freq / baudrate;
    endfunction

    // Clocks from accept edge to completion edge for one frame
    function automatic int unsigned frame_clks(input int unsigned bit_clks,
                                               input int unsigned data_bits,
                                               input int unsigned parity_bits,
                                               input int unsigned stop_bits);
        return (1 + data_bits + parity_bits + stop_bits) * bit_clks;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Clock-cycle counter for bit timing with synchronous clear and load.
// Terminal count is BIT_CLKS-1, or STOP_BITS*BIT_CLKS-1 when long_sel is high.
module uart_baud_cnt #(
    parameter int unsigned BIT_CLKS  = 10,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned CNT_W     = $clog2(STOP_BITS * BIT_CLKS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             long_sel,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC_SHORT = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] TC_LONG  = CNT_W'(STOP_BITS * BIT_CLKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = en && (cnt_q == (long_sel ? TC_LONG : TC_SHORT));

    // Next count: clear/load take priority, counter wraps only on its terminal compare
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (tc) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: START, DATA (LSB first), optional PARITY,
// STOP_BITS stop bits. Valid/ready input handshake, registered tx output.
// Parity is compiled in with the macro UART_TX_PARITY_EN.
module uart_tx_frame #(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned BAUDRATE   = 921600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 data_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    import uart_pkg::*;

    localparam int unsigned BIT_CLKS = calc_bit_clks(CLK_FREQ, BAUDRATE);
    localparam int unsigned CNT_W    = $clog2(STOP_BITS * BIT_CLKS);
    localparam int unsigned IDX_W    = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    // Elaboration-time parameter legality checks
    if (BIT_CLKS < MIN_BIT_CLKS) begin : g_chk_bit_clks
        $error("uart_tx_frame: BIT_CLKS must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_chk_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    tx_state_e            state_q, state_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic bit_tc;

    uart_baud_cnt #(
        .BIT_CLKS  (BIT_CLKS),
        .STOP_BITS (STOP_BITS),
        .CNT_W     (CNT_W)
    ) u_baud_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q == IDLE),
        .load     (1'b0),
        .load_val ('0),
        .en       (state_q != IDLE),
        .long_sel (state_q == STOP),
        .tc       (bit_tc)
    );

    // Next-state, shift and line-level logic; tx_d is the level for the next bit period
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                bit_idx_d = '0;
                if (data_valid) begin
                    state_d = START;
                    shreg_d = data;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (bit_tc) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                end
            end
            DATA: begin
                if (bit_tc) begin
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tc) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_tc) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at BIT_CLKS=10: 8N1 instance plus two
// 7-bit/2-stop instances (even and odd parity when UART_TX_PARITY_EN is set).
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
    localparam int P  = 1;
    localparam int F7 = 110;
`else
    localparam int P  = 0;
    localparam int F7 = 100;
`endif
    localparam int F8 = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] data8;
    logic       v8, ready8, tx8, busy8, done8;
    logic [6:0] data7;
    logic       v7, ready_e, tx_e, busy_e, done_e, ready_o, tx_o, busy_o, done_o;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    uart_tx_frame #(.CLK_FREQ(1000000), .BAUDRATE(100000), .DATA_BITS(8),
                    .STOP_BITS(1), .PARITY_ODD(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .data(data8), .data_valid(v8),
        .tx_ready(ready8), .tx(tx8), .tx_busy(busy8), .tx_done(done8));

    uart_tx_frame #(.CLK_FREQ(1000000), .BAUDRATE(100000), .DATA_BITS(7),
                    .STOP_BITS(2), .PARITY_ODD(0)) u_dut7e (
        .clk(clk), .rst_n(rst_n), .data(data7), .data_valid(v7),
        .tx_ready(ready_e), .tx(tx_e), .tx_busy(busy_e), .tx_done(done_e));

    uart_tx_frame #(.CLK_FREQ(1000000), .BAUDRATE(100000), .DATA_BITS(7),
                    .STOP_BITS(2), .PARITY_ODD(1)) u_dut7o (
        .clk(clk), .rst_n(rst_n), .data(data7), .data_valid(v7),
        .tx_ready(ready_o), .tx(tx_o), .tx_busy(busy_o), .tx_done(done_o));

    // Expected line level k clocks after the accept edge (BIT_CLKS=10)
    function automatic logic exp_tx(input logic [8:0] d, input int nbits,
                                    input int p, input logic pbit, input int k);
        int idx;
        if (k < 10) return 1'b0;
        idx = (k - 10) / 10;
        if (idx < nbits) return d[idx];
        if (p != 0 && idx == nbits) return pbit;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; v8 = 1'b0; v7 = 1'b0; data8 = '0; data7 = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (tx8 !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b want 1", tx8); end
        vectors++; if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready8); end
        vectors++; if (busy8 !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy8); end
        vectors++; if (done8 !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done8); end
        vectors++; if (tx_e !== 1'b1 || ready_o !== 1'b1)
            begin errors++; $display("FAIL reset_7bit: got tx=%b ready=%b want 1 1", tx_e, ready_o); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_8n1();
        data8 = 8'hA5; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0; data8 = 8'h00;
        for (int k = 0; k <= F8 + 1; k++) begin
            if (k < F8) begin
                vectors++; if (tx8 !== exp_tx({1'b0, 8'hA5}, 8, 0, 1'b0, k))
                    begin errors++; $display("FAIL 8n1_tx k=%0d: got %b want %b", k, tx8, exp_tx({1'b0, 8'hA5}, 8, 0, 1'b0, k)); end
                vectors++; if (done8 !== 1'b0 || busy8 !== 1'b1 || ready8 !== 1'b0)
                    begin errors++; $display("FAIL 8n1_flags k=%0d: got done=%b busy=%b ready=%b want 0 1 0", k, done8, busy8, ready8); end
            end else if (k == F8) begin
                vectors++; if (done8 !== 1'b1 || busy8 !== 1'b0 || ready8 !== 1'b1 || tx8 !== 1'b1)
                    begin errors++; $display("FAIL 8n1_end: got done=%b busy=%b ready=%b tx=%b want 1 0 1 1", done8, busy8, ready8, tx8); end
            end else begin
                vectors++; if (done8 !== 1'b0)
                    begin errors++; $display("FAIL 8n1_done_width: got %b want 0", done8); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_parity_7bit();
        logic [6:0] words [2] = '{7'h55, 7'h54};
        logic       pe    [2] = '{1'b0, 1'b1};
        logic       po    [2] = '{1'b1, 1'b0};
        for (int w = 0; w < 2; w++) begin
            data7 = words[w]; v7 = 1'b1;
            @(posedge clk); #1;
            v7 = 1'b0; data7 = '0;
            for (int k = 0; k <= F7 + 1; k++) begin
                if (k < F7) begin
                    vectors++; if (tx_e !== exp_tx({2'b00, words[w]}, 7, P, pe[w], k))
                        begin errors++; $display("FAIL par_even_tx w=%0d k=%0d: got %b want %b", w, k, tx_e, exp_tx({2'b00, words[w]}, 7, P, pe[w], k)); end
                    vectors++; if (tx_o !== exp_tx({2'b00, words[w]}, 7, P, po[w], k))
                        begin errors++; $display("FAIL par_odd_tx w=%0d k=%0d: got %b want %b", w, k, tx_o, exp_tx({2'b00, words[w]}, 7, P, po[w], k)); end
                    vectors++; if (done_e !== 1'b0 || done_o !== 1'b0)
                        begin errors++; $display("FAIL par_early_done k=%0d: got %b %b want 0 0", k, done_e, done_o); end
                end else if (k == F7) begin
                    vectors++; if (done_e !== 1'b1 || done_o !== 1'b1 || ready_e !== 1'b1 || busy_o !== 1'b0)
                        begin errors++; $display("FAIL par_end: got done=%b/%b ready=%b busy=%b want 1/1 1 0", done_e, done_o, ready_e, busy_o); end
                end else begin
                    vectors++; if (done_e !== 1'b0 || done_o !== 1'b0)
                        begin errors++; $display("FAIL par_done_width: got %b %b want 0 0", done_e, done_o); end
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        data8 = 8'h01; v8 = 1'b1;
        @(posedge clk); #1;
        data8 = 8'h02;
        for (int k = 0; k <= 2 * F8 + 5; k++) begin
            if (done8 === 1'b1) dones++;
            if (k < F8) begin
                vectors++; if (tx8 !== exp_tx(9'h001, 8, 0, 1'b0, k) || ready8 !== 1'b0)
                    begin errors++; $display("FAIL b2b_f1 k=%0d: got tx=%b ready=%b want %b 0", k, tx8, ready8, exp_tx(9'h001, 8, 0, 1'b0, k)); end
            end else if (k == F8) begin
                vectors++; if (done8 !== 1'b1 || tx8 !== 1'b1 || ready8 !== 1'b1)
                    begin errors++; $display("FAIL b2b_gap: got done=%b tx=%b ready=%b want 1 1 1", done8, tx8, ready8); end
            end else if (k <= 2 * F8) begin
                vectors++; if (tx8 !== exp_tx(9'h002, 8, 0, 1'b0, k - F8 - 1) || ready8 !== 1'b0)
                    begin errors++; $display("FAIL b2b_f2 k=%0d: got tx=%b ready=%b want %b 0", k, tx8, ready8, exp_tx(9'h002, 8, 0, 1'b0, k - F8 - 1)); end
                if (k == F8 + 1) v8 = 1'b0;
            end else if (k == 2 * F8 + 1) begin
                vectors++; if (done8 !== 1'b1 || ready8 !== 1'b1)
                    begin errors++; $display("FAIL b2b_end2: got done=%b ready=%b want 1 1", done8, ready8); end
            end else begin
                vectors++; if (tx8 !== 1'b1 || ready8 !== 1'b1)
                    begin errors++; $display("FAIL b2b_idle k=%0d: got tx=%b ready=%b want 1 1", k, tx8, ready8); end
            end
            @(posedge clk); #1;
        end
        vectors++; if (dones != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
    endtask

    task automatic test_reset_midframe();
        int dones = 0;
        int lows  = 0;
        data8 = 8'hC3; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        repeat (36) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vectors++; if (tx8 !== 1'b1 || ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0)
            begin errors++; $display("FAIL midrst_state: got tx=%b ready=%b busy=%b done=%b want 1 1 0 0", tx8, ready8, busy8, done8); end
        for (int k = 0; k < 120; k++) begin
            if (done8 === 1'b1) dones++;
            if (tx8 !== 1'b1) lows++;
            @(posedge clk); #1;
        end
        vectors++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", dones); end
        vectors++; if (lows != 0)  begin errors++; $display("FAIL midrst_line_idle: got %0d low clks want 0", lows); end
        data8 = 8'h3C; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        for (int k = 0; k <= F8; k++) begin
            if (k < F8) begin
                vectors++; if (tx8 !== exp_tx(9'h03C, 8, 0, 1'b0, k) || done8 !== 1'b0)
                    begin errors++; $display("FAIL midrst_frame k=%0d: got tx=%b done=%b want %b 0", k, tx8, done8, exp_tx(9'h03C, 8, 0, 1'b0, k)); end
            end else begin
                vectors++; if (done8 !== 1'b1 || tx8 !== 1'b1)
                    begin errors++; $display("FAIL midrst_frame_end: got done=%b tx=%b want 1 1", done8, tx8); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_data_change();
        data8 = 8'h5A; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        for (int k = 0; k <= F8 + 20; k++) begin
            if (k < F8) begin
                vectors++; if (tx8 !== exp_tx(9'h05A, 8, 0, 1'b0, k))
                    begin errors++; $display("FAIL chg_tx k=%0d: got %b want %b", k, tx8, exp_tx(9'h05A, 8, 0, 1'b0, k)); end
            end else if (k == F8) begin
                vectors++; if (done8 !== 1'b1)
                    begin errors++; $display("FAIL chg_done: got %b want 1", done8); end
            end else begin
                vectors++; if (tx8 !== 1'b1 || ready8 !== 1'b1 || done8 !== 1'b0)
                    begin errors++; $display("FAIL chg_no_second k=%0d: got tx=%b ready=%b done=%b want 1 1 0", k, tx8, ready8, done8); end
            end
            if (k == 30) begin data8 = 8'hFF; v8 = 1'b1; end
            if (k == 45) v8 = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_7bit();
        test_back_to_back();
        test_reset_midframe();
        test_data_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
